// File: rtl/rom_load_ctrl_if.sv
// HPS ioctl download stream in, region-decoded ROM write strobes out.
// Bundles the byte stream from hps_io and the ROM write port towards the game top.
interface rom_load_ctrl_if;
  // Neither side can stall. The master raises ioctl_wr for exactly one cycle
  // per byte while ioctl_download is high. The slave answers one cycle later
  // with a one-hot rom_we pulse that qualifies rom_addr/rom_data for that cycle.
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rom_we;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    input  rom_addr, rom_data, rom_we
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    output rom_addr, rom_data, rom_we
  );
endinterface

// File: rtl/rom_load_ctrl.sv
// Arcade ROM/DIP download sequencer: region decode, DIP bank, core reset stretch.
// Optional ROM checksum accumulator enabled by defining ROM_LOAD_CHECKSUM_EN.
module rom_load_ctrl #(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [7:0]  DIP_INDEX   = 8'd254,
  parameter logic [15:0] R0_END      = 16'h3000,
  parameter logic [15:0] R1_END      = 16'h3800,
  parameter logic [15:0] R2_END      = 16'h4000,
  parameter logic [15:0] R3_END      = 16'h4020,
  parameter logic [16:0] EXPECT_LEN  = 17'h04020,
  parameter logic [7:0]  HOLD_CYCLES = 8'd16
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  rst_req,
  rom_load_ctrl_if.slave        bus,
  output logic [63:0]           dip_sw,
  output logic                  core_reset,
  output logic                  load_ok,
  output logic                  overflow,
  output logic [15:0]           rom_sum,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  hold_cnt, hold_nxt;
  logic [7:0]  load_idx;
  logic [16:0] count;

  logic        wr_acc, rom_sel, dip_sel, entry, entry_rom, rom_hit;
  logic [3:0]  dec_we;
  logic [15:0] dec_addr;
  logic [16:0] cnt_base, cnt_inc;

  assign state_dbg = state;

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    core_reset = 1'b1;
    case (state)
      ST_RUN: begin
        core_reset = 1'b0;
        if (bus.ioctl_download) begin
          state_nxt = ST_LOAD;
        end else if (rst_req) begin
          state_nxt = ST_HOLD;
          hold_nxt  = HOLD_CYCLES;
        end
      end
      ST_LOAD: begin
        if (!bus.ioctl_download) begin
          state_nxt = ST_HOLD;
          hold_nxt  = HOLD_CYCLES;
        end
      end
      ST_HOLD: begin
        if (bus.ioctl_download) begin
          state_nxt = ST_LOAD;
        end else if (rst_req) begin
          hold_nxt = HOLD_CYCLES;
        end else if (hold_cnt == 8'd1) begin
          state_nxt = ST_RUN;
        end else begin
          hold_nxt = hold_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = ST_HOLD;
        hold_nxt  = HOLD_CYCLES;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state    <= ST_HOLD;
      hold_cnt <= HOLD_CYCLES;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Address decode: anything above 16 bits or past R3_END is out of range.
  always_comb begin
    dec_we   = 4'b0000;
    dec_addr = bus.ioctl_addr[15:0];
    if (bus.ioctl_addr[24:16] == 9'd0) begin
      if (bus.ioctl_addr[15:0] < R0_END) begin
        dec_we = 4'b0001;
      end else if (bus.ioctl_addr[15:0] < R1_END) begin
        dec_we   = 4'b0010;
        dec_addr = bus.ioctl_addr[15:0] - R0_END;
      end else if (bus.ioctl_addr[15:0] < R2_END) begin
        dec_we   = 4'b0100;
        dec_addr = bus.ioctl_addr[15:0] - R1_END;
      end else if (bus.ioctl_addr[15:0] < R3_END) begin
        dec_we   = 4'b1000;
        dec_addr = bus.ioctl_addr[15:0] - R2_END;
      end
    end
  end

  assign wr_acc    = bus.ioctl_download && bus.ioctl_wr;
  assign rom_sel   = (bus.ioctl_index == ROM_INDEX);
  assign dip_sel   = (bus.ioctl_index == DIP_INDEX);
  assign entry     = (state != ST_LOAD) && bus.ioctl_download;
  assign entry_rom = entry && rom_sel;
  assign rom_hit   = wr_acc && rom_sel && (dec_we != 4'b0000);
  // A byte may arrive on the very edge that starts a ROM download.
  assign cnt_base  = entry_rom ? 17'd0 : count;
  assign cnt_inc   = (cnt_base == 17'h1FFFF) ? cnt_base : cnt_base + 17'd1;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bus.rom_we   <= 4'b0000;
      bus.rom_addr <= 16'd0;
      bus.rom_data <= 8'd0;
      dip_sw       <= 64'd0;
      load_ok      <= 1'b0;
      overflow     <= 1'b0;
      count        <= 17'd0;
      load_idx     <= 8'd0;
    end else begin
      bus.rom_we <= 4'b0000;
      if (entry) begin
        load_idx <= bus.ioctl_index;
      end
      if (entry_rom) begin
        count    <= 17'd0;
        overflow <= 1'b0;
        load_ok  <= 1'b0;
      end
      if (state == ST_LOAD && !bus.ioctl_download && load_idx == ROM_INDEX) begin
        load_ok <= (count >= EXPECT_LEN) && !overflow;
      end
      if (rom_hit) begin
        bus.rom_we   <= dec_we;
        bus.rom_addr <= dec_addr;
        bus.rom_data <= bus.ioctl_dout;
        count        <= cnt_inc;
      end else if (wr_acc && rom_sel) begin
        overflow <= 1'b1;
      end
      if (wr_acc && dip_sel && bus.ioctl_addr[24:3] == 22'd0) begin
        dip_sw[{bus.ioctl_addr[2:0], 3'b000} +: 8] <= bus.ioctl_dout;
      end
    end
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sum_q <= 16'd0;
    end else if (rom_hit) begin
      sum_q <= (entry_rom ? 16'd0 : sum_q) + {8'd0, bus.ioctl_dout};
    end else if (entry_rom) begin
      sum_q <= 16'd0;
    end
  end

  assign rom_sum = sum_q;
`else
  assign rom_sum = 16'd0;
`endif

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl: behavioural model plus literal pins.
// Build with +define+ROM_LOAD_CHECKSUM_EN to exercise the checksum variant.
module tb_rom_load_ctrl;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        rst_req;
  logic [63:0] dip_sw;
  logic        core_reset, load_ok, overflow;
  logic [15:0] rom_sum;
  logic [1:0]  state_dbg;

  rom_load_ctrl_if bus();

  rom_load_ctrl dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .rst_req    (rst_req),
    .bus        (bus),
    .dip_sw     (dip_sw),
    .core_reset (core_reset),
    .load_ok    (load_ok),
    .overflow   (overflow),
    .rom_sum    (rom_sum),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  always #5 clk_sys = ~clk_sys;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Model: region table, download/hold bookkeeping, expected write queue
  int lo_tab[4] = '{'h0000, 'h3000, 'h3800, 'h4000};
  int hi_tab[4] = '{'h3000, 'h3800, 'h4000, 'h4020};

  logic [27:0] exp_q[$];
  logic [16:0] m_cnt;
  logic        m_ovf, m_ok, m_in_dl;
  logic [7:0]  m_idx;
  logic [15:0] m_sum;
  logic [63:0] m_dip;
  int          m_left;

  always @(posedge clk_sys) begin : model
    logic [16:0] cnt;
    logic        ovf, ok, found;
    logic [15:0] sum;
    logic [63:0] dip;
    int          a;
    if (!reset_n) begin
      m_in_dl <= 1'b0; m_left <= 16; m_cnt <= '0; m_ovf <= 1'b0;
      m_ok <= 1'b0; m_sum <= '0; m_dip <= '0; m_idx <= '0;
      exp_q.delete();
    end else begin
      cnt = m_cnt; ovf = m_ovf; ok = m_ok; sum = m_sum; dip = m_dip;
      if (bus.ioctl_download && !m_in_dl) begin
        m_idx <= bus.ioctl_index;
        if (bus.ioctl_index == 8'd0) begin
          cnt = '0; ovf = 1'b0; ok = 1'b0; sum = '0;
        end
      end
      if (!bus.ioctl_download && m_in_dl && m_idx == 8'd0)
        ok = (cnt >= 17'h04020) && !ovf;
      if (bus.ioctl_download && bus.ioctl_wr) begin
        a = int'(bus.ioctl_addr);
        if (bus.ioctl_index == 8'd0) begin
          found = 1'b0;
          for (int r = 0; r < 4; r++) begin
            if (a >= lo_tab[r] && a < hi_tab[r]) begin
              found = 1'b1;
              exp_q.push_back({4'(1 << r), 16'(a - lo_tab[r]), bus.ioctl_dout});
              if (cnt != 17'h1FFFF) cnt = cnt + 17'd1;
`ifdef ROM_LOAD_CHECKSUM_EN
              sum = sum + 16'(bus.ioctl_dout);
`endif
            end
          end
          if (!found) ovf = 1'b1;
        end else if (bus.ioctl_index == 8'd254 && a < 8) begin
          dip[a*8 +: 8] = bus.ioctl_dout;
        end
      end
      m_cnt <= cnt; m_ovf <= ovf; m_ok <= ok; m_sum <= sum; m_dip <= dip;
      if (bus.ioctl_download) m_in_dl <= 1'b1;
      else if (m_in_dl) begin m_in_dl <= 1'b0; m_left <= 16; end
      else if (rst_req) m_left <= 16;
      else if (m_left > 0) m_left <= m_left - 1;
    end
  end

  // Scoreboard / compare, sampled on the falling edge
  int tally[4];
  bit seen_3800;

  always @(negedge clk_sys) begin
    logic [27:0] e;
    if (chk_en) begin
      if (bus.rom_we != 4'b0000) begin
        for (int i = 0; i < 4; i++) if (bus.rom_we[i]) tally[i]++;
        if (bus.rom_we == 4'b0100 && bus.rom_addr == 16'd0) seen_3800 = 1'b1;
        if (exp_q.size() == 0) begin
          check("rom_wr_unexpected", {36'd0, bus.rom_we, bus.rom_addr, bus.rom_data}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rom_wr", {36'd0, bus.rom_we, bus.rom_addr, bus.rom_data}, {36'd0, e});
        end
      end
      if (exp_q.size() != 0) begin
        check("rom_wr_missing", 64'd0, {36'd0, exp_q[0]});
        exp_q.delete();
      end
      check("core_reset", 64'(core_reset), 64'(m_in_dl || m_left > 0));
      check("dip_sw", dip_sw, m_dip);
      check("load_ok", 64'(load_ok), 64'(m_ok));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("rom_sum", 64'(rom_sum), 64'(m_sum));
    end
  end

  // driver tasks
  task automatic start_dl(input logic [7:0] idx);
    bus.ioctl_index = idx;
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic send_byte(input int addr, input logic [7:0] data);
    bus.ioctl_addr = 25'(addr);
    bus.ioctl_dout = data;
    bus.ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  // counts core_reset-high cycles starting at the next falling edge
  task automatic measure_hold(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_sys);
      if (core_reset) n++;
      else break;
    end
  endtask

  task automatic clear_tally();
    for (int i = 0; i < 4; i++) tally[i] = 0;
    seen_3800 = 1'b0;
  endtask

  int n;

  initial begin
    reset_n = 1'b0; rst_req = 1'b0;
    bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0;
    bus.ioctl_index = 8'd0; bus.ioctl_addr = '0; bus.ioctl_dout = '0;
    clear_tally();
    repeat (3) @(posedge clk_sys); #1;
    chk_en = 1'b1;
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_rom_we", 64'(bus.rom_we), 64'd0);
    check("rst_dip_sw", dip_sw, 64'd0);
    reset_n = 1'b1;
    measure_hold(n);
    check("hold_after_reset", 64'(n), 64'd16);

    // short ROM load for the checksum
    start_dl(8'd0);
    send_byte(0, 8'hFF); send_byte(1, 8'h01); send_byte(2, 8'h80); send_byte(3, 8'h80);
    end_dl();
`ifdef ROM_LOAD_CHECKSUM_EN
    check("sum_4bytes", 64'(rom_sum), 64'h0200);
`else
    check("sum_disabled", 64'(rom_sum), 64'h0000);
`endif
    check("short_load_ok", 64'(load_ok), 64'd0);
    measure_hold(n);

    // full ROM image
    clear_tally();
    start_dl(8'd0);
    for (int a = 0; a < 'h4020; a++) send_byte(a, 8'(a));
    end_dl();
    check("full_tally0", 64'(tally[0]), 64'h3000);
    check("full_tally1", 64'(tally[1]), 64'h0800);
    check("full_tally2", 64'(tally[2]), 64'h0800);
    check("full_tally3", 64'(tally[3]), 64'h0020);
    check("full_3800_r2", 64'(seen_3800), 64'd1);
    check("full_load_ok", 64'(load_ok), 64'd1);
    check("full_overflow", 64'(overflow), 64'd0);
    measure_hold(n);
    check("hold_after_dl", 64'(n), 64'd16);

    // DIP bank
    start_dl(8'd254);
    for (int a = 0; a < 9; a++) send_byte(a, 8'(8'hA0 + a));
    end_dl();
    check("dip_value", dip_sw, 64'hA7A6A5A4A3A2A1A0);
    check("dip_keeps_load_ok", 64'(load_ok), 64'd1);
    measure_hold(n);

    // one byte too many
    clear_tally();
    start_dl(8'd0);
    for (int a = 0; a < 'h4021; a++) send_byte(a, 8'(a ^ 8'h5A));
    end_dl();
    check("ovf_tally3", 64'(tally[3]), 64'h0020);
    check("ovf_overflow", 64'(overflow), 64'd1);
    check("ovf_load_ok", 64'(load_ok), 64'd0);
    measure_hold(n);

    // rst_req pulse in RUN
    rst_req = 1'b1;
    @(posedge clk_sys); #1;
    rst_req = 1'b0;
    measure_hold(n);
    check("hold_rst_req", 64'(n), 64'd16);

    // rst_req held across an ignored-index download
    start_dl(8'd7);
    rst_req = 1'b1;
    for (int a = 0; a < 5; a++) send_byte(a, 8'hEE);
    repeat (20) @(posedge clk_sys); #1;
    check("load_ignores_rst_req", 64'(core_reset), 64'd1);
    rst_req = 1'b0;
    end_dl();
    measure_hold(n);
    check("hold_after_other_idx", 64'(n), 64'd16);

    // download rising mid-HOLD stays in LOAD past the old count
    rst_req = 1'b1;
    @(posedge clk_sys); #1;
    rst_req = 1'b0;
    repeat (5) @(posedge clk_sys); #1;
    start_dl(8'd254);
    repeat (30) @(posedge clk_sys); #1;
    check("load_from_hold", 64'(core_reset), 64'd1);
    end_dl();
    measure_hold(n);
    check("hold_after_mid_hold_dl", 64'(n), 64'd16);

    // reset mid-download, download continues afterwards
    start_dl(8'd0);
    for (int a = 0; a < 16; a++) send_byte(a, 8'(a + 3));
    reset_n = 1'b0;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    for (int a = 16; a < 20; a++) send_byte(a, 8'(a + 3));
    end_dl();
    check("rst_mid_dl_load_ok", 64'(load_ok), 64'd0);
    check("rst_mid_dl_dip", dip_sw, 64'd0);
    measure_hold(n);
    check("hold_after_rst_mid_dl", 64'(n), 64'd16);

    repeat (3) @(posedge clk_sys);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
